// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: default datapath width, the canonical NOP encoding
// and the sequential fetch increment.
package riscv_pkg;

    localparam int          DEFAULT_XLEN = 32;
    localparam logic [31:0] NOP_INST     = 32'h0000_0033;  // add x0,x0,x0
    localparam logic [31:0] PC_INC       = 32'h0000_0004;

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two circular buffer with occupancy counter and synchronous flush.
// Storage is deliberately left unreset; only pointers and count are cleared.
module sync_fifo #(
    parameter int  WIDTH = 64,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    // Storage write port; no reset so it maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_en) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: fetch-PC register and enq/deq/redirect control
// in front of a sync_fifo holding {pc, inst} pairs.
module if_prefetch_queue
    import riscv_pkg::*;
#(
    parameter int               XLEN     = DEFAULT_XLEN,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    localparam int              CW       = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst,
    output logic [CW-1:0]   count
);

    logic [XLEN-1:0]   fetch_pc_r;
    logic [CW-1:0]     count_s;
    logic [2*XLEN-1:0] head_s;
    logic              deq_s;
    logic              enq_s;
    logic              valid_s;

    assign valid_s = (count_s != {CW{1'b0}});
    // Full queue may still accept when the head leaves in the same cycle.
    assign deq_s   = valid_s & ~stall & ~redirect;
    assign enq_s   = ~redirect & ((count_s < CW'(DEPTH)) | deq_s);

    sync_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect),
        .wr_en   (enq_s),
        .wr_data ({fetch_pc_r, imem_rdata}),
        .rd_en   (deq_s),
        .rd_data (head_s),
        .count   (count_s)
    );

    // Fetch PC: redirect overrides, otherwise advance only on enqueue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
        end else if (redirect) begin
            fetch_pc_r <= redirect_pc;
        end else if (enq_s) begin
            fetch_pc_r <= fetch_pc_r + XLEN'(PC_INC);
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // Head view masks stale storage whenever the queue is empty.
    always_comb begin
        out_pc   = {XLEN{1'b0}};
        out_inst = XLEN'(NOP_INST);
        if (valid_s) begin
            out_pc   = head_s[2*XLEN-1:XLEN];
            out_inst = head_s[XLEN-1:0];
        end else begin
            out_pc   = {XLEN{1'b0}};
            out_inst = XLEN'(NOP_INST);
        end
    end

    assign imem_addr = fetch_pc_r;
    assign out_valid = valid_s;
    assign count     = count_s;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue; imem returns ~addr so each head
// instruction is predictable from its PC.
module tb_if_prefetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0033;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    if_prefetch_queue #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .count       (count)
    );

    assign imem_rdata = ~imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full head check: valid entry with the given PC.
    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] cnt,
                              input logic [31:0] addr);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".pc"},    out_pc, pc);
        check({tag, ".inst"},  out_inst, ~pc);
        check({tag, ".count"}, {29'd0, count}, cnt);
        check({tag, ".addr"},  imem_addr, addr);
    endtask

    // Empty-queue check: invalid head shows NOP and zero PC.
    task automatic check_empty(input string tag, input logic [31:0] addr);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".pc"},    out_pc, 32'd0);
        check({tag, ".inst"},  out_inst, NOP);
        check({tag, ".count"}, {29'd0, count}, 32'd0);
        check({tag, ".addr"},  imem_addr, addr);
    endtask

    initial begin
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        #2;
        check_empty("reset", 32'd0);
        step();
        step();
        rst = 1'b1;

        // Free-running stream: one entry in flight, PC advancing by 4.
        for (int k = 0; k < 6; k++) begin
            step();
            check_head("stream", 32'(4 * k), 32'd1, 32'(4 * k + 4));
        end

        // Build count to 3 then redirect to 0x40.
        stall = 1'b1;
        step();
        step();
        check_head("fill3", 32'h14, 32'd3, 32'h20);
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        check_empty("redir40", 32'h40);
        redirect = 1'b0;
        step();
        check_head("after40", 32'h40, 32'd1, 32'h44);

        // Back-to-back redirects: only the last target is fetched.
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        check_empty("redir100", 32'h100);
        redirect_pc = 32'h200;
        step();
        check_empty("redir200", 32'h200);
        redirect = 1'b0;
        step();
        check_head("after200", 32'h200, 32'd1, 32'h204);

        // Move stream to 0x24, then assert reset asynchronously mid-stream.
        redirect    = 1'b1;
        redirect_pc = 32'h24;
        step();
        redirect = 1'b0;
        step();
        check_head("at24", 32'h24, 32'd1, 32'h28);
        stall = 1'b1;
        rst   = 1'b0;
        #1;
        check_empty("async_rst", 32'd0);
        step();
        check_empty("rst_hold", 32'd0);
        rst = 1'b1;

        // Stall six cycles from empty: fill to 4 and freeze fetch at 0x10.
        for (int k = 1; k <= 6; k++) begin
            step();
            check_head("stall_fill", 32'd0, 32'((k < 4) ? k : 4), 32'(4 * ((k < 4) ? k : 4)));
        end

        // Full with no stall: enq+deq each cycle, in order, pointers wrap.
        stall = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            step();
            check_head("full_flow", 32'(4 * j), 32'd4, 32'(32'h10 + 4 * j));
        end

        // Full and stalled, then redirect with stall still high.
        stall = 1'b1;
        step();
        check_head("full_stall", 32'h28, 32'd4, 32'h38);
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        step();
        check_empty("redir_stall", 32'h80);
        redirect = 1'b0;
        step();
        check_head("after80", 32'h80, 32'd1, 32'h84);

        // Fetch PC wraps modulo 2^32.
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        check_empty("redir_top", 32'hFFFF_FFFC);
        redirect = 1'b0;
        step();
        check_head("pc_top", 32'hFFFF_FFFC, 32'd1, 32'd0);
        step();
        check_head("pc_wrap", 32'd0, 32'd1, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32: instruction/PC width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-003 SHALL have parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous active-low reset (asserted at 0).
REQ-006 SHALL have port imem_addr, output, XLEN: fetch PC driven to combinational instruction memory.
REQ-007 SHALL have port imem_rdata, input, XLEN: instruction at imem_addr, same cycle.
REQ-008 SHALL have port stall, input, 1: decode cannot accept the head this cycle.
REQ-009 SHALL have port redirect, input, 1: taken branch/jump resolved; flush and refetch.
REQ-010 SHALL have port redirect_pc, input, XLEN: new fetch target, valid with redirect.
REQ-011 SHALL have port out_valid, output, 1: queue head holds a valid instruction.
REQ-012 SHALL have port out_pc, output, XLEN: PC of the head entry.
REQ-013 SHALL have port out_inst, output, XLEN: head instruction; NOP when out_valid=0.
REQ-014 SHALL have port count, output, clog2(DEPTH+1): current occupancy.

Function
REQ-015 SHALL define deq = out_valid & ~stall & ~redirect, and enq = ~redirect & (count<DEPTH | deq).
REQ-016 SHALL, on enq, write {imem_addr, imem_rdata} at the tail and advance fetch PC by 4, modulo 2^XLEN.
REQ-017 SHALL, on deq, advance the head; simultaneous enq and deq leave count unchanged, including when full.
REQ-018 SHALL drive out_valid = (count != 0), with out_pc/out_inst read combinationally from head storage.
REQ-019 SHALL give a latency of 1 cycle: an instruction fetched in cycle N is at the head no earlier than cycle N+1.
REQ-020 SHALL, when full and not dequeuing, hold fetch PC, perform no enq, and drop no entry.
REQ-021 SHALL, on redirect (highest priority), clear count and head/tail pointers to 0, load fetch PC with redirect_pc, and perform no enq or deq that cycle.
REQ-022 SHALL drive out_valid=0 in the cycle after redirect; the redirect_pc instruction appears at the head that cycle+1.
REQ-023 SHALL let back-to-back redirects each override the previous one; only the last target is fetched.
REQ-024 SHALL keep out_inst at the NOP (add x0,x0,x0, 0x00000033) whenever out_valid=0.
REQ-025 SHALL wrap head and tail pointers modulo DEPTH with no bubble at wrap.
REQ-026 SHALL ignore stall when count=0.

Reset
REQ-027 SHALL, while rst=0, force fetch PC=RESET_PC, count=0, pointers=0, out_valid=0, out_inst=NOP and out_pc=0, asynchronously.
REQ-028 SHALL, on reset assertion mid-operation, discard all entries; the first fetch after release is RESET_PC.
REQ-029 SHALL leave storage array contents unreset; they are never observable while invalid.

Structure
REQ-030 SHALL take XLEN default, the NOP encoding and the PC increment constant from the shared package riscv_pkg.
REQ-031 SHALL implement storage and pointers as one sub-module, sync_fifo (parameters WIDTH=2*XLEN, DEPTH), with a synchronous flush input.
REQ-032 SHALL keep the fetch-PC register and the enq/deq/redirect control in if_prefetch_queue itself.

Verification
REQ-033 SHALL cover reset then no stall: out_pc = 0,4,8,... on consecutive cycles from cycle 1, count stays at 1.
REQ-034 SHALL cover stall held for 6 cycles, DEPTH=4: count reaches 4, imem_addr freezes at 0x10, then out_pc resumes at 0 in order with no loss or duplication on release.
REQ-035 SHALL cover redirect to 0x40 while count=3: next cycle out_valid=0 and out_inst=0x00000033; the following cycle out_pc=0x40.
REQ-036 SHALL cover redirect with stall=1 and the queue full simultaneously: redirect wins, count=0 next cycle.
REQ-037 SHALL cover full queue with stall low: enq and deq occur in the same cycle and count holds at 4 for 10 cycles; pointers wrap.
REQ-038 SHALL cover rst pulsed low mid-stream at PC 0x24: outputs clear immediately, and after release fetch restarts at RESET_PC.
